// File: rtl/arith_seq_counter_pkg.sv
`default_nettype none
// ==========================================================================
// arith_seq_pkg: shared mode/state types for arith_seq_counter.  Rev 1.0
// ==========================================================================
package arith_seq_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP   = 2'd0,
    MODE_SAT    = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_UP   = 2'd0,
    ST_DOWN = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/arith_seq_counter_if.sv
`default_nettype none
// ==========================================================================
// arith_seq_counter_if: control/config/status bundle.  Rev 1.0
// ==========================================================================
interface arith_seq_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             cfg_load;
  logic [WIDTH-1:0] cfg_start;
  logic [WIDTH-1:0] cfg_step;
  logic [WIDTH-1:0] cfg_limit;
  logic [1:0]       cfg_mode;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             done;
  logic             dir_down;
  logic             cfg_err;

  modport master (
    output en, cfg_load, cfg_start, cfg_step, cfg_limit, cfg_mode,
    input  count, tc, done, dir_down, cfg_err
  );

  modport slave (
    input  en, cfg_load, cfg_start, cfg_step, cfg_limit, cfg_mode,
    output count, tc, done, dir_down, cfg_err
  );
endinterface
`default_nettype wire

// File: rtl/arith_seq_counter_step.sv
`default_nettype none
// ==========================================================================
// arith_seq_step: next/previous candidates and boundary tests.  Rev 1.0
// ==========================================================================
module arith_seq_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH-1:0] step,
  input  logic [WIDTH-1:0] start,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH:0]   nxt,
  output logic [WIDTH:0]   prv,
  output logic             up_bnd,
  output logic             dn_bnd,
  output logic             up_ok,
  output logic             dn_ok
);
  // Extra MSB carries the overflow (nxt) or borrow (prv).
  always_comb begin
    nxt    = {1'b0, count} + {1'b0, step};
    prv    = {1'b0, count} - {1'b0, step};
    up_bnd = nxt[WIDTH] || (nxt[WIDTH-1:0] > limit);
    dn_bnd = prv[WIDTH] || (prv[WIDTH-1:0] < start);
    up_ok  = !up_bnd && (nxt[WIDTH-1:0] >= start);
    dn_ok  = !dn_bnd && (prv[WIDTH-1:0] <= limit);
  end
endmodule
`default_nettype wire

// File: rtl/arith_seq_counter.sv
`default_nettype none
// ==========================================================================
// arith_seq_counter: runtime-configurable arithmetic-sequence counter.  Rev 1.0
// ==========================================================================
module arith_seq_counter
  import arith_seq_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int DEF_START = 1,
  parameter int DEF_STEP  = 2,
  parameter int DEF_LIMIT = 9
) (
  input  logic                clk,
  input  logic                reset,
  arith_seq_counter_if.slave  bus
);
  localparam logic [WIDTH-1:0] START_RST = WIDTH'(DEF_START);
  localparam logic [WIDTH-1:0] STEP_RST  = WIDTH'(DEF_STEP);
  localparam logic [WIDTH-1:0] LIMIT_RST = WIDTH'(DEF_LIMIT);

  logic [WIDTH-1:0] start_q, step_q, limit_q, count_q;
  logic [WIDTH-1:0] start_d, step_d, limit_d, count_d;
  mode_e            mode_q, mode_d;
  state_e           state_q, state_d;
  logic             tc_q, done_q, dir_q, err_q;
  logic             tc_d, done_d, dir_d, err_d;

  logic [WIDTH:0]   nxt, prv;
  logic             up_bnd, dn_bnd, up_ok, dn_ok;

  arith_seq_step #(.WIDTH(WIDTH)) u_step (
    .count  (count_q),
    .step   (step_q),
    .start  (start_q),
    .limit  (limit_q),
    .nxt    (nxt),
    .prv    (prv),
    .up_bnd (up_bnd),
    .dn_bnd (dn_bnd),
    .up_ok  (up_ok),
    .dn_ok  (dn_ok)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      start_q <= START_RST;
      step_q  <= STEP_RST;
      limit_q <= LIMIT_RST;
      mode_q  <= MODE_WRAP;
      state_q <= ST_UP;
      count_q <= START_RST;
      tc_q    <= 1'b0;
      done_q  <= 1'b0;
      dir_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      start_q <= start_d;
      step_q  <= step_d;
      limit_q <= limit_d;
      mode_q  <= mode_d;
      state_q <= state_d;
      count_q <= count_d;
      tc_q    <= tc_d;
      done_q  <= done_d;
      dir_q   <= dir_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    start_d = start_q;
    step_d  = step_q;
    limit_d = limit_q;
    mode_d  = mode_q;
    state_d = state_q;
    count_d = count_q;
    tc_d    = 1'b0;
    done_d  = done_q;
    dir_d   = dir_q;
    err_d   = err_q;

    if (bus.cfg_load) begin
      start_d = bus.cfg_start;
      step_d  = bus.cfg_step;
      limit_d = bus.cfg_limit;
      mode_d  = mode_e'(bus.cfg_mode);
      state_d = ST_UP;
      count_d = bus.cfg_start;
      done_d  = 1'b0;
      dir_d   = 1'b0;
      err_d   = (bus.cfg_start > bus.cfg_limit);
    end else if (bus.en && !err_q && (step_q != '0)) begin
      unique case (state_q)
        ST_UP: begin
          if (!up_bnd) begin
            count_d = nxt[WIDTH-1:0];
          end else begin
            tc_d = 1'b1;
            case (mode_q)
              MODE_SAT: begin
                state_d = ST_HOLD;
                done_d  = 1'b1;
              end
              MODE_BOUNCE: begin
                state_d = ST_DOWN;
                dir_d   = 1'b1;
                if (dn_ok) count_d = prv[WIDTH-1:0];
              end
              default: count_d = start_q;  // WRAP and the reserved encoding
            endcase
          end
        end
        ST_DOWN: begin
          if (!dn_bnd) begin
            count_d = prv[WIDTH-1:0];
          end else begin
            tc_d    = 1'b1;
            state_d = ST_UP;
            dir_d   = 1'b0;
            if (up_ok) count_d = nxt[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.count    = count_q;
  assign bus.tc       = tc_q;
  assign bus.done     = done_q;
  assign bus.dir_down = dir_q;
  assign bus.cfg_err  = err_q;
endmodule
`default_nettype wire

// File: tb/tb_arith_seq_counter.sv
`default_nettype none
// ==========================================================================
// tb_arith_seq_counter: directed + randomized check against a reference model.
// ==========================================================================
module tb_arith_seq_counter;
  localparam int W = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  arith_seq_counter_if #(.WIDTH(W)) bus ();

  arith_seq_counter #(
    .WIDTH(W), .DEF_START(1), .DEF_STEP(2), .DEF_LIMIT(9)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state: plain integers, limits checked with full-range arithmetic.
  int m_start, m_step, m_limit, m_mode, m_count;
  int m_desc, m_hold, m_tc, m_done, m_err;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit in_range(input int v);
    return (v >= m_start) && (v <= m_limit);
  endfunction

  task automatic model_clock();
    if (reset) begin
      m_start = 1; m_step = 2; m_limit = 9; m_mode = 0; m_count = 1;
      m_desc = 0; m_hold = 0; m_tc = 0; m_done = 0; m_err = 0;
    end else if (bus.cfg_load) begin
      m_start = bus.cfg_start; m_step = bus.cfg_step; m_limit = bus.cfg_limit;
      m_mode  = bus.cfg_mode;  m_count = m_start;
      m_desc = 0; m_hold = 0; m_tc = 0; m_done = 0;
      m_err = (m_start > m_limit);
    end else begin
      m_tc = 0;
      if (bus.en && !m_err && m_step != 0 && !m_hold) begin
        if (!m_desc) begin
          if (m_count + m_step <= m_limit) m_count = m_count + m_step;
          else begin
            m_tc = 1;
            if (m_mode == 1) begin
              m_hold = 1; m_done = 1;
            end else if (m_mode == 2) begin
              m_desc = 1;
              if (in_range(m_count - m_step)) m_count = m_count - m_step;
            end else m_count = m_start;
          end
        end else begin
          if (m_count - m_step >= m_start) m_count = m_count - m_step;
          else begin
            m_tc = 1; m_desc = 0;
            if (in_range(m_count + m_step)) m_count = m_count + m_step;
          end
        end
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_clock();
    #1;
    check("count",    int'(bus.count),    m_count);
    check("tc",       int'(bus.tc),       m_tc);
    check("done",     int'(bus.done),     m_done);
    check("dir_down", int'(bus.dir_down), m_desc);
    check("cfg_err",  int'(bus.cfg_err),  m_err);
  endtask

  task automatic set_in(input bit r, input bit e, input bit l,
                        input int s, input int st, input int li, input int md);
    reset         = r;
    bus.en        = e;
    bus.cfg_load  = l;
    bus.cfg_start = s[W-1:0];
    bus.cfg_step  = st[W-1:0];
    bus.cfg_limit = li[W-1:0];
    bus.cfg_mode  = md[1:0];
  endtask

  int exp1_c[5]  = '{3, 5, 7, 9, 1};
  int exp1_t[5]  = '{0, 0, 0, 0, 1};
  int exp2_c[6]  = '{3, 6, 9, 9, 9, 9};
  int exp2_d[6]  = '{0, 0, 0, 1, 1, 1};
  int exp3_c[9]  = '{3, 5, 7, 9, 7, 5, 3, 1, 3};
  int exp3_t[9]  = '{0, 0, 0, 0, 1, 0, 0, 0, 1};
  int exp3_d[9]  = '{0, 0, 0, 0, 1, 1, 1, 1, 0};

  initial begin
    set_in(1, 0, 0, 0, 0, 0, 0);
    cycle();
    check("rst_count", int'(bus.count), 1);

    // Defaults: odd-number sequence with wrap
    set_in(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("t1_count", int'(bus.count), exp1_c[i]);
      check("t1_tc",    int'(bus.tc),    exp1_t[i]);
    end

    // Saturate
    set_in(0, 1, 1, 0, 3, 10, 1);
    cycle();
    check("t2_load", int'(bus.count), 0);
    set_in(0, 1, 0, 0, 3, 10, 1);
    for (int i = 0; i < 6; i++) begin
      cycle();
      check("t2_count", int'(bus.count), exp2_c[i]);
      check("t2_done",  int'(bus.done),  exp2_d[i]);
    end

    // Bounce
    set_in(0, 1, 1, 1, 2, 9, 2);
    cycle();
    set_in(0, 1, 0, 1, 2, 9, 2);
    for (int i = 0; i < 9; i++) begin
      cycle();
      check("t3_count", int'(bus.count),    exp3_c[i]);
      check("t3_tc",    int'(bus.tc),       exp3_t[i]);
      check("t3_dir",   int'(bus.dir_down), exp3_d[i]);
    end

    // Carry-out wrap
    set_in(0, 1, 1, 13, 4, 15, 0);
    cycle();
    set_in(0, 1, 0, 13, 4, 15, 0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("t4_count", int'(bus.count), 13);
      check("t4_tc",    int'(bus.tc),    1);
    end

    // Bad config, then zero step
    set_in(0, 1, 1, 9, 2, 3, 0);
    cycle();
    set_in(0, 1, 0, 9, 2, 3, 0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("t5_err",   int'(bus.cfg_err), 1);
      check("t5_count", int'(bus.count),   9);
    end
    set_in(0, 1, 1, 2, 0, 12, 0);
    cycle();
    set_in(0, 1, 0, 2, 0, 12, 0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("t5_step0", int'(bus.count), 2);
    end

    // Reset overrides en and cfg_load mid-sequence
    set_in(0, 1, 1, 4, 3, 14, 2);
    cycle();
    set_in(0, 1, 0, 4, 3, 14, 2);
    for (int i = 0; i < 4; i++) cycle();
    set_in(1, 1, 1, 6, 5, 12, 1);
    cycle();
    check("t6_count", int'(bus.count),    1);
    check("t6_dir",   int'(bus.dir_down), 0);
    set_in(0, 1, 0, 6, 5, 12, 1);
    for (int i = 0; i < 6; i++) cycle();

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      int s, li;
      s  = int'($urandom_range(0, 15));
      li = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15))
                                        : int'($urandom_range(s, 15));
      set_in($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
             $urandom_range(0, 11) == 0, s, int'($urandom_range(0, 6)),
             li, int'($urandom_range(0, 3)));
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
